mem_port_arbiter: RTL and testbench

- Shares one single-port unified memory between the pipeline's instruction-fetch (IF) stage and data-memory (MEM) stage.
- Sequences each access with a req/ack handshake to memory and performs byte/halfword lane selection, sign extension and write replication.
- Drives the global pipeline stall until every pending requester has been served.
- Consumes the 2-bit MemRead/MemWrite codes produced by the main decoder: 00 none, 01 word, 10 byte, 11 half.

---
 rtl/mem_port_arbiter_pkg.sv | 25 ++
 rtl/mem_lane_align.sv | 59 +++++
 rtl/mem_port_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified memory port: access-size codes from the
// main decoder and the arbiter state encoding.
package mem_port_arbiter_pkg;

   localparam logic [1:0] MEM_NONE = 2'b00;
   localparam logic [1:0] MEM_WORD = 2'b01;
   localparam logic [1:0] MEM_BYTE = 2'b10;
   localparam logic [1:0] MEM_HALF = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DATA  = 2'd1,
      ST_FETCH = 2'd2
   } arb_state_t;

   // Bytes are always aligned; halves need addr[0]=0, words addr[1:0]=00.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
      case (size)
         MEM_WORD: return (lo != 2'b00);
         MEM_HALF: return lo[0];
         default:  return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the unified memory port: store byte enables and data
// replication, load lane extraction with sign extension.
module mem_lane_align
   import mem_port_arbiter_pkg::*;
(
   input  logic [1:0]  wr_size,
   input  logic [1:0]  wr_lo,
   input  logic [31:0] wr_data,
   output logic [3:0]  wr_be,
   output logic [31:0] wr_rep,
   input  logic [1:0]  rd_size,
   input  logic [1:0]  rd_lo,
   input  logic [31:0] rd_word,
   output logic [31:0] rd_ext
);

   function automatic logic signed [31:0] sext_byte(input logic signed [7:0] b);
      return {{24{b[7]}}, b};
   endfunction

   function automatic logic signed [31:0] sext_half(input logic signed [15:0] h);
      return {{16{h[15]}}, h};
   endfunction

   logic [7:0]  rd_byte;
   logic [15:0] rd_half;

   always_comb begin
      wr_be  = 4'b1111;
      wr_rep = wr_data;
      case (wr_size)
         MEM_BYTE: begin
            wr_be  = 4'b0001 << wr_lo;
            wr_rep = {4{wr_data[7:0]}};
         end
         MEM_HALF: begin
            wr_be  = wr_lo[1] ? 4'b1100 : 4'b0011;
            wr_rep = {2{wr_data[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      case (rd_lo)
         2'd0:    rd_byte = rd_word[7:0];
         2'd1:    rd_byte = rd_word[15:8];
         2'd2:    rd_byte = rd_word[23:16];
         default: rd_byte = rd_word[31:24];
      endcase
      rd_half = rd_lo[1] ? rd_word[31:16] : rd_word[15:0];
      case (rd_size)
         MEM_BYTE: rd_ext = sext_byte(rd_byte);
         MEM_HALF: rd_ext = sext_half(rd_half);
         default:  rd_ext = rd_word;
      endcase
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and data access,
// holding the pipeline stall until every pending requester has been served.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int MAX_WAIT = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [31:0]       if_rdata,
   output logic              if_ready,
   input  logic [1:0]        dm_read,
   input  logic [1:0]        dm_write,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [31:0]       dm_wdata,
   output logic [31:0]       dm_rdata,
   output logic              dm_ready,
   output logic              stall,
   output logic              misalign_err,
   output logic              timeout_err,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_be,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ack
);

   localparam int               CNT_W    = $clog2(MAX_WAIT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

   arb_state_t        state, state_nxt;
   logic [CNT_W-1:0]  wait_cnt, wait_cnt_nxt;
   logic              if_served, if_served_nxt;
   logic              dm_served, dm_served_nxt;
   logic [1:0]        acc_size, acc_size_nxt;
   logic [1:0]        acc_lo, acc_lo_nxt;
   logic [31:0]       if_rdata_nxt, dm_rdata_nxt, mem_wdata_nxt;
   logic              if_ready_nxt, dm_ready_nxt, misalign_nxt, timeout_nxt;
   logic              mem_req_nxt, mem_we_nxt;
   logic [ADDR_W-1:0] mem_addr_nxt;
   logic [3:0]        mem_be_nxt;
   logic [3:0]        lane_be;
   logic [31:0]       lane_wdata, lane_rdata;
   logic              dm_is_wr, dm_pend, if_pend, dm_mis, if_mis, acc_done;
   logic [1:0]        dm_size;

   // A non-zero write code turns the access into a store regardless of dm_read.
   assign dm_is_wr = (dm_write != MEM_NONE);
   assign dm_size  = dm_is_wr ? dm_write : dm_read;
   assign dm_pend  = ((dm_read != MEM_NONE) || dm_is_wr) && !dm_served;
   assign if_pend  = if_req && !if_served;
   assign stall    = dm_pend || if_pend;
   assign dm_mis   = is_misaligned(dm_size, dm_addr[1:0]);
   assign if_mis   = is_misaligned(MEM_WORD, if_addr[1:0]);
   assign acc_done = mem_ack || (wait_cnt == CNT_LAST);

   mem_lane_align u_lane (
      .wr_size (dm_size),
      .wr_lo   (dm_addr[1:0]),
      .wr_data (dm_wdata),
      .wr_be   (lane_be),
      .wr_rep  (lane_wdata),
      .rd_size (acc_size),
      .rd_lo   (acc_lo),
      .rd_word (mem_rdata),
      .rd_ext  (lane_rdata)
   );

   always_comb begin
      state_nxt     = state;
      wait_cnt_nxt  = wait_cnt;
      if_served_nxt = if_served;
      dm_served_nxt = dm_served;
      acc_size_nxt  = acc_size;
      acc_lo_nxt    = acc_lo;
      if_rdata_nxt  = if_rdata;
      dm_rdata_nxt  = dm_rdata;
      if_ready_nxt  = 1'b0;
      dm_ready_nxt  = 1'b0;
      misalign_nxt  = 1'b0;
      timeout_nxt   = 1'b0;
      mem_req_nxt   = mem_req;
      mem_we_nxt    = mem_we;
      mem_addr_nxt  = mem_addr;
      mem_be_nxt    = mem_be;
      mem_wdata_nxt = mem_wdata;

      case (state)
         ST_IDLE: begin
            if (dm_pend) begin
               if (dm_mis) begin
                  dm_ready_nxt  = 1'b1;
                  misalign_nxt  = 1'b1;
                  dm_rdata_nxt  = '0;
                  dm_served_nxt = 1'b1;
               end else begin
                  state_nxt     = ST_DATA;
                  wait_cnt_nxt  = '0;
                  mem_req_nxt   = 1'b1;
                  mem_we_nxt    = dm_is_wr;
                  mem_addr_nxt  = {dm_addr[ADDR_W-1:2], 2'b00};
                  mem_be_nxt    = dm_is_wr ? lane_be : 4'b1111;
                  mem_wdata_nxt = dm_is_wr ? lane_wdata : '0;
                  acc_size_nxt  = dm_size;
                  acc_lo_nxt    = dm_addr[1:0];
               end
            end else if (if_pend) begin
               if (if_mis) begin
                  if_ready_nxt  = 1'b1;
                  misalign_nxt  = 1'b1;
                  if_rdata_nxt  = '0;
                  if_served_nxt = 1'b1;
               end else begin
                  state_nxt     = ST_FETCH;
                  wait_cnt_nxt  = '0;
                  mem_req_nxt   = 1'b1;
                  mem_we_nxt    = 1'b0;
                  mem_addr_nxt  = {if_addr[ADDR_W-1:2], 2'b00};
                  mem_be_nxt    = 4'b1111;
                  mem_wdata_nxt = '0;
               end
            end
         end
         ST_DATA: begin
            if (acc_done) begin
               state_nxt     = ST_IDLE;
               wait_cnt_nxt  = '0;
               mem_req_nxt   = 1'b0;
               mem_we_nxt    = 1'b0;
               dm_ready_nxt  = 1'b1;
               timeout_nxt   = !mem_ack;
               dm_served_nxt = 1'b1;
               dm_rdata_nxt  = mem_ack ? lane_rdata : '0;
            end else begin
               wait_cnt_nxt  = wait_cnt + CNT_W'(1);
            end
         end
         ST_FETCH: begin
            if (acc_done) begin
               state_nxt     = ST_IDLE;
               wait_cnt_nxt  = '0;
               mem_req_nxt   = 1'b0;
               mem_we_nxt    = 1'b0;
               if_ready_nxt  = 1'b1;
               timeout_nxt   = !mem_ack;
               if_served_nxt = 1'b1;
               if_rdata_nxt  = mem_ack ? mem_rdata : '0;
            end else begin
               wait_cnt_nxt  = wait_cnt + CNT_W'(1);
            end
         end
         default: state_nxt = ST_IDLE;
      endcase

      // Once the pipeline advances, the next instruction's requests are fresh.
      if (!stall) begin
         if_served_nxt = 1'b0;
         dm_served_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         wait_cnt     <= '0;
         if_served    <= 1'b0;
         dm_served    <= 1'b0;
         if_rdata     <= '0;
         dm_rdata     <= '0;
         if_ready     <= 1'b0;
         dm_ready     <= 1'b0;
         misalign_err <= 1'b0;
         timeout_err  <= 1'b0;
         mem_req      <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_be       <= '0;
         mem_wdata    <= '0;
      end else begin
         state        <= state_nxt;
         wait_cnt     <= wait_cnt_nxt;
         if_served    <= if_served_nxt;
         dm_served    <= dm_served_nxt;
         if_rdata     <= if_rdata_nxt;
         dm_rdata     <= dm_rdata_nxt;
         if_ready     <= if_ready_nxt;
         dm_ready     <= dm_ready_nxt;
         misalign_err <= misalign_nxt;
         timeout_err  <= timeout_nxt;
         mem_req      <= mem_req_nxt;
         mem_we       <= mem_we_nxt;
         mem_addr     <= mem_addr_nxt;
         mem_be       <= mem_be_nxt;
         mem_wdata    <= mem_wdata_nxt;
      end
   end

   // Lane steering for the in-flight load; only meaningful while an access is open.
   always_ff @(posedge clk) begin
      acc_size <= acc_size_nxt;
      acc_lo   <= acc_lo_nxt;
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: a transaction-level timeline model
// predicts every cycle of each instruction's memory traffic and results.
module tb_mem_port_arbiter;
   import mem_port_arbiter_pkg::*;

   localparam int MW = 16;

   logic        clk;
   logic        rst_n;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_ready;
   logic [1:0]  dm_read;
   logic [1:0]  dm_write;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [31:0] dm_rdata;
   logic        dm_ready;
   logic        stall;
   logic        misalign_err;
   logic        timeout_err;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   mem_port_arbiter #(.ADDR_W(32), .MAX_WAIT(MW)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .if_req       (if_req),
      .if_addr      (if_addr),
      .if_rdata     (if_rdata),
      .if_ready     (if_ready),
      .dm_read      (dm_read),
      .dm_write     (dm_write),
      .dm_addr      (dm_addr),
      .dm_wdata     (dm_wdata),
      .dm_rdata     (dm_rdata),
      .dm_ready     (dm_ready),
      .stall        (stall),
      .misalign_err (misalign_err),
      .timeout_err  (timeout_err),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_be       (mem_be),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata),
      .mem_ack      (mem_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_errs   = 0;
   logic [31:0] mem_model [0:63];
   logic [31:0] obs_dm, obs_wd;
   logic [3:0]  obs_be;
   logic        obs_we, obs_mis, obs_to;

   task automatic chk1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Cycle (relative to start c) on which an access's ready pulse must appear.
   function automatic int acc_end(input int c, input logic mis, input int dly);
      if (mis)          return c + 1;
      else if (dly < 0) return c + MW + 1;
      else              return c + 2 + dly;
   endfunction

   task automatic idle_cycles(input int n);
      if_req = 1'b0; dm_read = MEM_NONE; dm_write = MEM_NONE; mem_ack = 1'b0;
      for (int k = 0; k < n; k++) begin
         mem_rdata = $urandom;
         #1;
         chk1("idle_stall", stall, 1'b0);
         chk1("idle_mem_req", mem_req, 1'b0);
         chk1("idle_dm_ready", dm_ready, 1'b0);
         chk1("idle_if_ready", if_ready, 1'b0);
         @(posedge clk); #1;
      end
   endtask

   // One pipeline instruction: optional data access, then optional fetch.
   // dly = ack wait cycles after mem_req rises, or -1 for no ack at all.
   task automatic run_instr(input logic fe, input logic [31:0] faddr,
                            input logic [1:0] rd, input logic [1:0] wr,
                            input logic [31:0] daddr, input logic [31:0] wdata,
                            input int dly_d, input int dly_f);
      logic        has_d, is_wr, d_mis, f_mis, in_d, in_f, ack_now;
      logic [1:0]  sz;
      int          c_d, r_d, c_f, r_f, last, v, sh;
      logic [31:0] word_d, word_f, exp_d, exp_f, exp_wd, rword;
      logic [3:0]  exp_be;
      has_d = (rd != MEM_NONE) || (wr != MEM_NONE);
      is_wr = (wr != MEM_NONE);
      sz    = is_wr ? wr : rd;
      d_mis = has_d && ((sz == MEM_WORD && daddr[1:0] != 2'b00) || (sz == MEM_HALF && daddr[0]));
      f_mis = fe && (faddr[1:0] != 2'b00);
      c_d = 0;
      r_d = has_d ? acc_end(c_d, d_mis, dly_d) : -1;
      c_f = has_d ? r_d : 0;
      r_f = fe ? acc_end(c_f, f_mis, dly_f) : -1;
      last = fe ? r_f : r_d;

      word_d = mem_model[daddr[7:2]];
      exp_be = 4'b1111;
      exp_wd = wdata;
      exp_d  = word_d;
      if (sz == MEM_BYTE) begin
         exp_be = 4'b0001 << daddr[1:0];
         exp_wd = 32'(wdata[7:0]) * 32'h01010101;
         sh = 8 * int'(daddr[1:0]);
         v  = int'((word_d >> sh) & 32'hFF);
         if (v > 127) v -= 256;
         exp_d = 32'(v);
      end else if (sz == MEM_HALF) begin
         exp_be = daddr[1] ? 4'b1100 : 4'b0011;
         exp_wd = 32'(wdata[15:0]) * 32'h00010001;
         sh = 16 * int'(daddr[1]);
         v  = int'((word_d >> sh) & 32'hFFFF);
         if (v > 32767) v -= 65536;
         exp_d = 32'(v);
      end
      if (d_mis || dly_d < 0) exp_d = '0;
      if (has_d && is_wr && !d_mis && dly_d >= 0)
         for (int j = 0; j < 4; j++)
            if (exp_be[j]) mem_model[daddr[7:2]][8*j +: 8] = exp_wd[8*j +: 8];
      word_f = mem_model[faddr[7:2]];
      exp_f  = (f_mis || dly_f < 0) ? 32'h0 : word_f;

      for (int i = 0; i <= last; i++) begin
         if (i == 0) begin
            if_req = fe; if_addr = faddr; dm_read = rd; dm_write = wr;
            dm_addr = daddr; dm_wdata = wdata;
         end
         ack_now = 1'b0;
         rword   = $urandom;
         if (has_d && !d_mis && dly_d >= 0 && i == c_d + 1 + dly_d) begin
            ack_now = 1'b1; rword = word_d;
         end
         if (fe && !f_mis && dly_f >= 0 && i == c_f + 1 + dly_f) begin
            ack_now = 1'b1; rword = word_f;
         end
         mem_ack = ack_now; mem_rdata = rword;
         #1;
         in_d = has_d && !d_mis && i > c_d && i < r_d;
         in_f = fe && !f_mis && i > c_f && i < r_f;
         chk1("stall", stall, i != last);
         chk1("mem_req", mem_req, in_d || in_f);
         if (in_d) begin
            chk1("d_mem_we", mem_we, is_wr);
            chk32("d_mem_addr", mem_addr, {daddr[31:2], 2'b00});
            chk32("d_mem_be", 32'(mem_be), 32'(is_wr ? exp_be : 4'b1111));
            if (is_wr) chk32("d_mem_wdata", mem_wdata, exp_wd);
            if (i == c_d + 1) begin obs_be = mem_be; obs_wd = mem_wdata; obs_we = mem_we; end
         end
         if (in_f) begin
            chk1("f_mem_we", mem_we, 1'b0);
            chk32("f_mem_addr", mem_addr, {faddr[31:2], 2'b00});
            chk32("f_mem_be", 32'(mem_be), 32'hF);
         end
         chk1("dm_ready", dm_ready, has_d && i == r_d);
         chk1("if_ready", if_ready, fe && i == r_f);
         chk1("misalign_err", misalign_err, (has_d && i == r_d && d_mis) || (fe && i == r_f && f_mis));
         chk1("timeout_err", timeout_err, (has_d && i == r_d && !d_mis && dly_d < 0) ||
                                          (fe && i == r_f && !f_mis && dly_f < 0));
         if (has_d && i == r_d) begin
            obs_dm = dm_rdata; obs_mis = misalign_err; obs_to = timeout_err;
            if (!is_wr || d_mis || dly_d < 0) chk32("dm_rdata", dm_rdata, exp_d);
         end
         if (fe && i == r_f) chk32("if_rdata", if_rdata, exp_f);
         @(posedge clk); #1;
      end
   endtask

   logic        r_fe;
   logic [1:0]  r_rd, r_wr, r_sz;
   logic [31:0] r_fa, r_da;
   int          op;

   function automatic int pick_dly();
      int r;
      r = $urandom_range(0, 29);
      if (r == 0) return -1;
      if (r == 1) return MW - 1;
      return $urandom_range(0, 4);
   endfunction

   initial begin
      for (int k = 0; k < 64; k++) mem_model[k] = $urandom;
      rst_n = 1'b0; if_req = 1'b0; if_addr = '0; dm_read = MEM_NONE; dm_write = MEM_NONE;
      dm_addr = '0; dm_wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
      obs_dm = '0; obs_wd = '0; obs_be = '0; obs_we = 1'b0; obs_mis = 1'b0; obs_to = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk1("rst_mem_req", mem_req, 1'b0);
      chk1("rst_stall", stall, 1'b0);
      chk1("rst_dm_ready", dm_ready, 1'b0);
      chk1("rst_if_ready", if_ready, 1'b0);
      chk1("rst_misalign", misalign_err, 1'b0);
      chk1("rst_timeout", timeout_err, 1'b0);
      chk32("rst_dm_rdata", dm_rdata, 32'h0);
      chk32("rst_mem_be", 32'(mem_be), 32'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      mem_model[0] = 32'hDEADBEEF;
      run_instr(1'b0, 32'h0, MEM_WORD, MEM_NONE, 32'h100, 32'h0, 0, 0);
      chk32("lw_lit_rdata", obs_dm, 32'hDEADBEEF);
      chk32("lw_lit_be", 32'(obs_be), 32'hF);
      idle_cycles(1);
      mem_model[0] = 32'h80FFFFFF;
      run_instr(1'b0, 32'h0, MEM_BYTE, MEM_NONE, 32'h103, 32'h0, 1, 0);
      chk32("lb_lit_rdata", obs_dm, 32'hFFFFFF80);
      mem_model[0] = 32'h7FFF0000;
      run_instr(1'b0, 32'h0, MEM_HALF, MEM_NONE, 32'h102, 32'h0, 2, 0);
      chk32("lh_lit_rdata", obs_dm, 32'h00007FFF);
      run_instr(1'b0, 32'h0, MEM_NONE, MEM_BYTE, 32'h101, 32'h000000AB, 0, 0);
      chk1("sb_lit_we", obs_we, 1'b1);
      chk32("sb_lit_be", 32'(obs_be), 32'h2);
      chk32("sb_lit_wdata", obs_wd, 32'hABABABAB);
      run_instr(1'b1, 32'h180, MEM_WORD, MEM_NONE, 32'h104, 32'h0, 1, 1);
      run_instr(1'b0, 32'h0, MEM_WORD, MEM_NONE, 32'h102, 32'h0, 0, 0);
      chk32("mis_lit_rdata", obs_dm, 32'h0);
      chk1("mis_lit_err", obs_mis, 1'b1);
      run_instr(1'b0, 32'h0, MEM_WORD, MEM_NONE, 32'h108, 32'h0, -1, 0);
      chk1("to_lit_err", obs_to, 1'b1);
      idle_cycles(2);

      // Reset while a data access is waiting for its ack.
      dm_read = MEM_WORD; dm_addr = 32'h104; mem_ack = 1'b0;
      #1; chk1("mrst_stall0", stall, 1'b1);
      @(posedge clk); #1; chk1("mrst_req1", mem_req, 1'b1);
      @(posedge clk); #1; chk1("mrst_req2", mem_req, 1'b1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk1("mrst_req_drop", mem_req, 1'b0);
      chk1("mrst_no_ready", dm_ready, 1'b0);
      chk1("mrst_no_timeout", timeout_err, 1'b0);
      chk1("mrst_stall_in", stall, 1'b1);
      rst_n = 1'b1; dm_read = MEM_NONE;
      #1; chk1("mrst_stall_clr", stall, 1'b0);
      @(posedge clk); #1;
      chk1("mrst_req_idle", mem_req, 1'b0);
      chk1("mrst_ready_idle", dm_ready, 1'b0);

      for (int n = 0; n < 300; n++) begin
         r_fe = ($urandom_range(0, 9) != 0);
         op   = $urandom_range(0, 7);
         r_rd = MEM_NONE; r_wr = MEM_NONE;
         if (op >= 1 && op <= 3) r_rd = 2'(op);
         if (op >= 4 && op <= 6) r_wr = 2'(op - 3);
         if (op == 7) begin r_rd = 2'($urandom_range(1, 3)); r_wr = 2'($urandom_range(1, 3)); end
         if (!r_fe && op == 0) r_fe = 1'b1;
         r_sz = (r_wr != MEM_NONE) ? r_wr : r_rd;
         r_da = 32'h100 + 32'($urandom_range(0, 255));
         if ($urandom_range(0, 3) != 0) begin
            if (r_sz == MEM_WORD) r_da[1:0] = 2'b00;
            if (r_sz == MEM_HALF) r_da[0] = 1'b0;
         end
         r_fa = 32'h100 + 32'(4 * $urandom_range(0, 63));
         if ($urandom_range(0, 9) == 0) r_fa[1:0] = 2'($urandom_range(1, 3));
         run_instr(r_fe, r_fa, r_rd, r_wr, r_da, $urandom, pick_dly(), pick_dly());
         idle_cycles($urandom_range(0, 2));
      end

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
      $fatal(1, "watchdog expired");
   end

endmodule
